sdr_app_req_queue: RTL and testbench
====================================

Name: sdr_app_req_queue

Overview:
- Application-side front end for the SDRAM controller; sits directly upstream of the controller's application request port.
- Buffers host burst requests and the write data belonging to them.
- Drives the controller's request handshake: app_req / app_req_addr / app_req_len / app_req_wr_n / app_req_wrap, acknowledged by app_req_ack.
- Supplies app_wr_data / app_wr_en_n on each app_wr_next_req pulse.

Parameters:
APP_AW, 26, request address width
APP_RW, 9, burst length field width (length in 32-bit words)
APP_DW, 32, application data width
APP_BW, 4, byte-enable width (APP_DW/8)
REQ_DEPTH, 4, request FIFO entries (power of 2)
WD_DEPTH, 64, write-data FIFO entries (power of 2, >= max burst)

Ports:
sdram_clk  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
host_req_valid  in  1  host request valid
host_req_ready  out  1  request FIFO not full
host_req_addr  in  APP_AW  burst start address
host_req_len  in  APP_RW  burst length in words, 1..2^APP_RW-1
host_req_wr_n  in  1  0 write, 1 read
host_req_wrap  in  1  address wrap
host_wd_valid  in  1  write word valid
host_wd_ready  out  1  write-data FIFO not full
host_wd_data  in  APP_DW  write word
host_wd_en_n  in  APP_BW  byte enables, active low
app_req  out  1  request to controller
app_req_addr  out  APP_AW  to controller
app_req_len  out  APP_RW  to controller
app_req_wr_n  out  1  to controller
app_req_wrap  out  1  to controller
app_req_ack  in  1  controller accepted request
app_wr_next_req  in  1  controller consumes one write word this cycle
app_wr_data  out  APP_DW  head of write-data FIFO
app_wr_en_n  out  APP_BW  head byte enables
wd_underflow  out  1  sticky: app_wr_next_req while write FIFO empty
len_zero_err  out  1  sticky: host pushed host_req_len == 0

Behaviour:
- Reset (async assert, sync deassert via flop behaviour) forces:
  - app_req=0, all app_req_* fields = 0
  - app_wr_data=0, app_wr_en_n = all 1s
  - sticky flags = 0, FIFOs empty, FSM in IDLE
  - host_req_ready=1, host_wd_ready=1 one cycle after deassertion
- Host pushes:
  - Request push on host_req_valid & host_req_ready.
  - len==0 requests are dropped and set len_zero_err.
  - Write-data push on host_wd_valid & host_wd_ready.
- FSM states: IDLE, REQ, WDATA.
  - IDLE -> REQ when the request FIFO is non-empty and either:
    - the head is a read, or
    - the head is a write and write FIFO count >= head len.
  - Register the head fields onto app_req_*, assert app_req the next cycle (latency 1 from eligibility).
- REQ: app_req and all fields held stable until app_req_ack.
  - On ack: pop the request FIFO and deassert app_req in the following cycle.
  - Read goes to IDLE; write loads a remaining-word counter with len and goes to WDATA.
- WDATA: each app_wr_next_req pops one word and decrements the counter.
  - At 0, go to IDLE.
  - No new request is presented in WDATA.
- app_wr_data / app_wr_en_n are the combinational FIFO head (first-word fall-through).
  - Valid in the same cycle as app_wr_next_req.
  - Show 0 / all-ones when the FIFO is empty.
- app_wr_next_req while the write FIFO is empty:
  - No pop, wd_underflow set.
  - Counter still decrements so the FSM cannot hang.
- Simultaneous push and pop on a full FIFO: the push is refused (ready is based on pre-pop count). Push and pop on a non-full FIFO both occur.
- Back-to-back requests: IDLE re-evaluates the cycle after REQ/WDATA exit, giving a minimum 1 idle cycle between app_req pulses.
- reset_n low mid-burst aborts everything: no partial state is retained and counters clear.

Optional Feature:
- Macro SDR_APP_REQ_QUEUE_STATS_EN.
- Defined: adds ports rd_req_cnt and wr_req_cnt (16 bits each, out).
  - Each increments on app_req_ack for its type, wrapping at 0xFFFF.
  - Cleared by reset.
- Undefined: ports and logic are absent.

Decomposition:
- Package sdr_app_pkg holds:
  - APP_* width localparams
  - req_t struct {addr, len, wr_n, wrap}
  - wd_t struct {data, en_n}
  - FSM enum {IDLE, REQ, WDATA}
- One generic sub-module, sdr_sync_fifo: parameterised width/depth, first-word fall-through, count output.
  - Instantiated twice: req_t and wd_t.

Test Plan:
- Read request addr=0x100, len=4, wr_n=1 -> app_req rises the cycle after push; fields stable; ack at cycle 3 -> app_req low next cycle; FSM back to IDLE.
- Write len=8 with only 5 words pushed -> app_req stays 0; push 3 more words -> app_req asserts; 8 app_wr_next_req pulses return data in push order with matching en_n.
- Fill request FIFO with 4 reads, ack withheld -> host_req_ready=0; 5th push refused; after one ack, ready=1 next cycle.
- app_wr_next_req with write FIFO empty -> wd_underflow=1 sticky, app_wr_data=0.
- Request push with len=0 -> dropped, len_zero_err=1, app_req never asserts.
- reset_n pulled low during WDATA after 3 of 8 words -> all outputs at reset values immediately; fresh read after release is served normally.

Source files
------------

// File: rtl/sdr_app_pkg.sv
// rtl/sdr_app_pkg.sv - shared widths, request/write-word structs and FSM states for the app request queue
package sdr_app_pkg;

    localparam int APP_AW = 26;
    localparam int APP_RW = 9;
    localparam int APP_DW = 32;
    localparam int APP_BW = APP_DW / 8;

    typedef struct packed {
        logic [APP_AW-1:0] addr;
        logic [APP_RW-1:0] len;
        logic              wr_n;
        logic              wrap;
    } req_t;

    typedef struct packed {
        logic [APP_DW-1:0] data;
        logic [APP_BW-1:0] en_n;
    } wd_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WDATA
    } state_e;

endpackage

// File: rtl/sdr_sync_fifo.sv
// rtl/sdr_sync_fifo.sv - generic first-word fall-through synchronous FIFO with occupancy count
module sdr_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // Push acceptance uses the pre-pop count, so a full FIFO refuses a push even when popping.
    assign do_push = push_i & (count_q != (AW+1)'(DEPTH));
    assign do_pop  = pop_i & (count_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sdr_app_req_queue.sv
// rtl/sdr_app_req_queue.sv - host request/write-data buffering and SDRAM app request handshake; optional SDR_APP_REQ_QUEUE_STATS_EN
module sdr_app_req_queue
    import sdr_app_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int WD_DEPTH  = 64
) (
    input  logic              sdram_clk,
    input  logic              reset_n,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic [APP_AW-1:0] host_req_addr,
    input  logic [APP_RW-1:0] host_req_len,
    input  logic              host_req_wr_n,
    input  logic              host_req_wrap,
    input  logic              host_wd_valid,
    output logic              host_wd_ready,
    input  logic [APP_DW-1:0] host_wd_data,
    input  logic [APP_BW-1:0] host_wd_en_n,
    output logic              app_req,
    output logic [APP_AW-1:0] app_req_addr,
    output logic [APP_RW-1:0] app_req_len,
    output logic              app_req_wr_n,
    output logic              app_req_wrap,
    input  logic              app_req_ack,
    input  logic              app_wr_next_req,
    output logic [APP_DW-1:0] app_wr_data,
    output logic [APP_BW-1:0] app_wr_en_n,
`ifdef SDR_APP_REQ_QUEUE_STATS_EN
    output logic [15:0]       rd_req_cnt,
    output logic [15:0]       wr_req_cnt,
`endif
    output logic              wd_underflow,
    output logic              len_zero_err
);

    localparam int RCW = $clog2(REQ_DEPTH) + 1;
    localparam int WCW = $clog2(WD_DEPTH) + 1;

    req_t            req_in, req_head;
    wd_t             wd_in, wd_head;
    logic [RCW-1:0]  req_count;
    logic [WCW-1:0]  wd_count;
    logic            req_empty, wd_empty;
    logic            req_accept, req_push, req_pop;
    logic            wd_push, wd_pop;
    logic            head_eligible;

    state_e            state_q;
    logic              app_req_q;
    logic [APP_AW-1:0] addr_q;
    logic [APP_RW-1:0] len_q;
    logic              wr_n_q;
    logic              wrap_q;
    logic [APP_RW-1:0] remaining_q;
    logic              wd_underflow_q;
    logic              len_zero_err_q;

    assign req_in = '{addr: host_req_addr, len: host_req_len, wr_n: host_req_wr_n, wrap: host_req_wrap};
    assign wd_in  = '{data: host_wd_data, en_n: host_wd_en_n};

    assign host_req_ready = (req_count != RCW'(REQ_DEPTH));
    assign host_wd_ready  = (wd_count != WCW'(WD_DEPTH));
    assign req_empty      = (req_count == '0);
    assign wd_empty       = (wd_count == '0);

    // Zero-length requests complete the handshake but never enter the queue.
    assign req_accept = host_req_valid & host_req_ready;
    assign req_push   = req_accept & (host_req_len != '0);
    assign req_pop    = (state_q == REQ) & app_req_ack;
    assign wd_push    = host_wd_valid & host_wd_ready;
    assign wd_pop     = app_wr_next_req & ~wd_empty;

    // A write is only offered once its whole burst is buffered, so the controller never starves.
    assign head_eligible = ~req_empty & (req_head.wr_n | (APP_RW'(wd_count) >= req_head.len));

    sdr_sync_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk_i   (sdram_clk),
        .rst_ni  (reset_n),
        .push_i  (req_push),
        .wdata_i (req_in),
        .pop_i   (req_pop),
        .rdata_o (req_head),
        .count_o (req_count)
    );

    sdr_sync_fifo #(
        .WIDTH ($bits(wd_t)),
        .DEPTH (WD_DEPTH)
    ) u_wd_fifo (
        .clk_i   (sdram_clk),
        .rst_ni  (reset_n),
        .push_i  (wd_push),
        .wdata_i (wd_in),
        .pop_i   (wd_pop),
        .rdata_o (wd_head),
        .count_o (wd_count)
    );

    always_ff @(posedge sdram_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            app_req_q      <= 1'b0;
            addr_q         <= '0;
            len_q          <= '0;
            wr_n_q         <= 1'b0;
            wrap_q         <= 1'b0;
            remaining_q    <= '0;
            wd_underflow_q <= 1'b0;
            len_zero_err_q <= 1'b0;
        end else begin
            if (app_wr_next_req && wd_empty) wd_underflow_q <= 1'b1;
            if (req_accept && (host_req_len == '0)) len_zero_err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (head_eligible) begin
                        app_req_q <= 1'b1;
                        addr_q    <= req_head.addr;
                        len_q     <= req_head.len;
                        wr_n_q    <= req_head.wr_n;
                        wrap_q    <= req_head.wrap;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (app_req_ack) begin
                        app_req_q <= 1'b0;
                        if (wr_n_q) begin
                            state_q <= IDLE;
                        end else begin
                            remaining_q <= len_q;
                            state_q     <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    // Underflowed beats still count down so a starved burst cannot wedge the FSM.
                    if (app_wr_next_req) begin
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q <= APP_RW'(1)) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign app_req      = app_req_q;
    assign app_req_addr = addr_q;
    assign app_req_len  = len_q;
    assign app_req_wr_n = wr_n_q;
    assign app_req_wrap = wrap_q;
    assign app_wr_data  = wd_empty ? '0 : wd_head.data;
    assign app_wr_en_n  = wd_empty ? '1 : wd_head.en_n;
    assign wd_underflow = wd_underflow_q;
    assign len_zero_err = len_zero_err_q;

`ifdef SDR_APP_REQ_QUEUE_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge sdram_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (req_pop) begin
            if (wr_n_q) rd_cnt_q <= rd_cnt_q + 1'b1;
            else        wr_cnt_q <= wr_cnt_q + 1'b1;
        end
    end

    assign rd_req_cnt = rd_cnt_q;
    assign wr_req_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sdr_app_req_queue.sv
// tb/tb_sdr_app_req_queue.sv - scoreboard bench for sdr_app_req_queue with random traffic and directed corner cases
module tb_sdr_app_req_queue;
    import sdr_app_pkg::*;

    logic              sdram_clk = 1'b0;
    logic              reset_n;
    logic              host_req_valid, host_req_ready;
    logic [APP_AW-1:0] host_req_addr;
    logic [APP_RW-1:0] host_req_len;
    logic              host_req_wr_n, host_req_wrap;
    logic              host_wd_valid, host_wd_ready;
    logic [APP_DW-1:0] host_wd_data;
    logic [APP_BW-1:0] host_wd_en_n;
    logic              app_req;
    logic [APP_AW-1:0] app_req_addr;
    logic [APP_RW-1:0] app_req_len;
    logic              app_req_wr_n, app_req_wrap;
    logic              app_req_ack, app_wr_next_req;
    logic [APP_DW-1:0] app_wr_data;
    logic [APP_BW-1:0] app_wr_en_n;
    logic              wd_underflow, len_zero_err;
`ifdef SDR_APP_REQ_QUEUE_STATS_EN
    logic [15:0]       rd_req_cnt, wr_req_cnt;
`endif

    always #5 sdram_clk = ~sdram_clk;

    sdr_app_req_queue dut (
        .sdram_clk       (sdram_clk),
        .reset_n         (reset_n),
        .host_req_valid  (host_req_valid),
        .host_req_ready  (host_req_ready),
        .host_req_addr   (host_req_addr),
        .host_req_len    (host_req_len),
        .host_req_wr_n   (host_req_wr_n),
        .host_req_wrap   (host_req_wrap),
        .host_wd_valid   (host_wd_valid),
        .host_wd_ready   (host_wd_ready),
        .host_wd_data    (host_wd_data),
        .host_wd_en_n    (host_wd_en_n),
        .app_req         (app_req),
        .app_req_addr    (app_req_addr),
        .app_req_len     (app_req_len),
        .app_req_wr_n    (app_req_wr_n),
        .app_req_wrap    (app_req_wrap),
        .app_req_ack     (app_req_ack),
        .app_wr_next_req (app_wr_next_req),
        .app_wr_data     (app_wr_data),
        .app_wr_en_n     (app_wr_en_n),
`ifdef SDR_APP_REQ_QUEUE_STATS_EN
        .rd_req_cnt      (rd_req_cnt),
        .wr_req_cnt      (wr_req_cnt),
`endif
        .wd_underflow    (wd_underflow),
        .len_zero_err    (len_zero_err)
    );

    int   vectors = 0;
    int   miscompares = 0;
    req_t exp_req_q[$];
    wd_t  exp_wd_q[$];
    bit   m_underflow, m_lenzero, ctrl_stop;

    bit   prev_req, ack_seen;
    req_t held, e_req;
    wd_t  e_wd;
    int   wr_left, avail_prev, avail_now;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops the expected request on each app_req rise and an expected word on each app_wr_next_req.
    always @(negedge sdram_clk) begin
        if (!reset_n) begin
            prev_req    = 1'b0;
            ack_seen    = 1'b0;
            wr_left     = 0;
            avail_prev  = 0;
            m_underflow = 1'b0;
        end else begin
            avail_now = exp_wd_q.size();
            chk("underflow_flag", wd_underflow, m_underflow);
            chk("len_zero_flag", len_zero_err, m_lenzero);
            if (ack_seen) chk("req_drop_after_ack", app_req, 0);
            ack_seen = 1'b0;
            if (app_req && !prev_req) begin
                chk("req_during_wdata", wr_left, 0);
                if (exp_req_q.size() == 0) begin
                    chk("req_unexpected", app_req, 0);
                end else begin
                    e_req = exp_req_q.pop_front();
                    chk("req_fields", {app_req_addr, app_req_len, app_req_wr_n, app_req_wrap}, e_req);
                    if (!e_req.wr_n) chk("wr_req_early", app_req && (avail_prev < int'(e_req.len)), 0);
                end
                held = '{addr: app_req_addr, len: app_req_len, wr_n: app_req_wr_n, wrap: app_req_wrap};
            end else if (app_req) begin
                chk("req_stable", {app_req_addr, app_req_len, app_req_wr_n, app_req_wrap}, held);
            end
            if (app_req && app_req_ack) begin
                ack_seen = 1'b1;
                if (!app_req_wr_n) wr_left = int'(app_req_len);
            end
            if (app_wr_next_req) begin
                if (wr_left > 0) wr_left--;
                if (exp_wd_q.size() > 0) begin
                    e_wd = exp_wd_q.pop_front();
                    chk("wr_data", {app_wr_data, app_wr_en_n}, e_wd);
                end else begin
                    chk("wr_data_empty", {app_wr_data, app_wr_en_n}, {32'h0, 4'hF});
                    m_underflow = 1'b1;
                end
            end
            prev_req   = app_req;
            avail_prev = avail_now;
        end
    end

    task automatic push_req(input logic [APP_AW-1:0] a, input logic [APP_RW-1:0] l,
                            input logic wn, input logic wp, input int max_wait, output bit acc);
        @(posedge sdram_clk); #1;
        host_req_valid = 1'b1;
        host_req_addr  = a;
        host_req_len   = l;
        host_req_wr_n  = wn;
        host_req_wrap  = wp;
        acc = 1'b0;
        for (int i = 0; i <= max_wait && !acc; i++) begin
            @(negedge sdram_clk); #1;
            if (host_req_ready) begin
                acc = 1'b1;
                if (l != 0) exp_req_q.push_back('{addr: a, len: l, wr_n: wn, wrap: wp});
                else        m_lenzero = 1'b1;
            end
            @(posedge sdram_clk); #1;
        end
        host_req_valid = 1'b0;
    endtask

    task automatic push_wd(input logic [APP_DW-1:0] d, input logic [APP_BW-1:0] en, input int max_wait, output bit acc);
        @(posedge sdram_clk); #1;
        host_wd_valid = 1'b1;
        host_wd_data  = d;
        host_wd_en_n  = en;
        acc = 1'b0;
        for (int i = 0; i <= max_wait && !acc; i++) begin
            @(negedge sdram_clk); #1;
            if (host_wd_ready) begin
                acc = 1'b1;
                exp_wd_q.push_back('{data: d, en_n: en});
            end
            @(posedge sdram_clk); #1;
        end
        host_wd_valid = 1'b0;
    endtask

    task automatic do_ack();
        for (int t = 0; t < 50 && !app_req; t++) @(negedge sdram_clk);
        chk("ack_wait_req", app_req, 1);
        @(posedge sdram_clk); #1;
        app_req_ack = 1'b1;
        @(posedge sdram_clk); #1;
        app_req_ack = 1'b0;
    endtask

    task automatic pulse_next(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sdram_clk); #1;
            app_wr_next_req = 1'b1;
            @(posedge sdram_clk); #1;
            app_wr_next_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        host_req_valid = 1'b0; host_wd_valid = 1'b0;
        app_req_ack = 1'b0; app_wr_next_req = 1'b0;
        exp_req_q.delete();
        exp_wd_q.delete();
        m_lenzero = 1'b0;
        repeat (2) @(posedge sdram_clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_app_req"}, app_req, 0);
        chk({tag, "_req_fields"}, {app_req_addr, app_req_len, app_req_wr_n, app_req_wrap}, 0);
        chk({tag, "_wr_data"}, {app_wr_data, app_wr_en_n}, {32'h0, 4'hF});
        chk({tag, "_flags"}, {wd_underflow, len_zero_err}, 0);
    endtask

    task automatic controller();
        int  d, n;
        bit  wr;
        while (!ctrl_stop) begin
            @(negedge sdram_clk);
            if (app_req && reset_n) begin
                d = $urandom_range(0, 3);
                repeat (d) @(negedge sdram_clk);
                @(posedge sdram_clk); #1;
                wr = !app_req_wr_n;
                n  = int'(app_req_len);
                app_req_ack = 1'b1;
                @(posedge sdram_clk); #1;
                app_req_ack = 1'b0;
                if (wr) begin
                    for (int i = 0; i < n; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge sdram_clk); #1; end
                        app_wr_next_req = 1'b1;
                        @(posedge sdram_clk); #1;
                        app_wr_next_req = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic random_driver();
        bit acc;
        logic [APP_RW-1:0] l;
        logic wn;
        for (int k = 0; k < 40; k++) begin
            l  = ($urandom_range(0, 19) == 0) ? APP_RW'(0) : APP_RW'($urandom_range(1, 12));
            wn = 1'($urandom_range(0, 1));
            push_req(APP_AW'($urandom), l, wn, 1'($urandom_range(0, 1)), 1000, acc);
            chk("rnd_req_accept", acc, 1);
            if (!wn && l != 0) begin
                for (int j = 0; j < int'(l); j++) begin
                    push_wd($urandom, APP_BW'($urandom), 1000, acc);
                    chk("rnd_wd_accept", acc, 1);
                end
            end
        end
        for (int t = 0; t < 3000 && (exp_req_q.size() != 0 || exp_wd_q.size() != 0); t++) @(negedge sdram_clk);
        chk("rnd_drain_pending", exp_req_q.size() + exp_wd_q.size(), 0);
        repeat (4) @(negedge sdram_clk);
        ctrl_stop = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        host_req_addr = '0; host_req_len = '0; host_req_wr_n = 1'b0; host_req_wrap = 1'b0;
        host_wd_data = '0; host_wd_en_n = '0;
        ctrl_stop = 1'b0;
        reset_n = 1'b0;
        host_req_valid = 1'b0; host_wd_valid = 1'b0;
        app_req_ack = 1'b0; app_wr_next_req = 1'b0;
        m_lenzero = 1'b0;
        @(negedge sdram_clk);
        check_reset_outputs("rst");
        do_reset();
        @(negedge sdram_clk);
        chk("rst_ready", {host_req_ready, host_wd_ready}, 2'b11);

        // Read: app_req one cycle after the accepting edge, held until ack, dropped right after.
        push_req(26'h100, 9'd4, 1'b1, 1'b0, 10, acc);
        @(negedge sdram_clk); chk("rd_lat0", app_req, 0);
        @(negedge sdram_clk); chk("rd_lat1", app_req, 1);
        chk("rd_fields", {app_req_addr, app_req_len, app_req_wr_n}, {26'h100, 9'd4, 1'b1});
        @(negedge sdram_clk); chk("rd_hold", app_req, 1);
        do_ack();
        @(negedge sdram_clk); chk("rd_release", app_req, 0);

        // Write len 8 waits until all 8 words are buffered.
        push_req(26'h2A0, 9'd8, 1'b0, 1'b1, 10, acc);
        for (int i = 0; i < 5; i++) push_wd(32'hA000_0000 + i, APP_BW'(i), 10, acc);
        repeat (4) begin @(negedge sdram_clk); chk("wr_wait_words", app_req, 0); end
        for (int i = 5; i < 8; i++) push_wd(32'hA000_0000 + i, APP_BW'(i), 10, acc);
        @(negedge sdram_clk); chk("wr_lat0", app_req, 0);
        @(negedge sdram_clk); chk("wr_lat1", app_req, 1);
        do_ack();
        pulse_next(8);
        @(negedge sdram_clk); chk("wr_fifo_empty", {app_wr_data, app_wr_en_n}, {32'h0, 4'hF});

        // Request FIFO full with ack withheld.
        for (int i = 0; i < 4; i++) push_req(APP_AW'(26'h400 + i), 9'd2, 1'b1, 1'b0, 10, acc);
        @(negedge sdram_clk); chk("full_ready", host_req_ready, 0);
        push_req(26'h3FF, 9'd1, 1'b1, 1'b0, 0, acc);
        chk("full_push_refused", acc, 0);
        do_ack();
        @(negedge sdram_clk); chk("ready_after_ack", host_req_ready, 1);
        repeat (3) do_ack();
        repeat (2) @(negedge sdram_clk);
        chk("full_drained_idle", app_req, 0);

        // Underflow: beat requested from an empty write FIFO.
        @(posedge sdram_clk); #1 app_wr_next_req = 1'b1;
        @(negedge sdram_clk); chk("uf_data", {app_wr_data, app_wr_en_n}, {32'h0, 4'hF});
        @(posedge sdram_clk); #1 app_wr_next_req = 1'b0;
        repeat (3) begin @(negedge sdram_clk); chk("uf_sticky", wd_underflow, 1); end

        // Zero-length request is dropped.
        push_req(26'h55, 9'd0, 1'b1, 1'b0, 10, acc);
        repeat (4) begin @(negedge sdram_clk); chk("len0_no_req", app_req, 0); end
        chk("len0_err", len_zero_err, 1);

        // Reset in the middle of a write burst.
        do_reset();
        push_req(26'h1234, 9'd8, 1'b0, 1'b0, 10, acc);
        for (int i = 0; i < 8; i++) push_wd(32'hB0B0_0000 + i, 4'h5, 10, acc);
        do_ack();
        pulse_next(3);
        reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        chk("midrst_ready", {host_req_ready, host_wd_ready}, 2'b11);
        do_reset();
        push_req(26'h777, 9'd3, 1'b1, 1'b0, 10, acc);
        do_ack();
        @(negedge sdram_clk); chk("post_rst_release", app_req, 0);
        chk("post_rst_clean", {app_wr_data, app_wr_en_n}, {32'h0, 4'hF});

        // Random traffic against the scoreboard.
        do_reset();
        fork
            random_driver();
            controller();
        join

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
